// File: rtl/ocm_port_arbiter_if.sv
// Requester-side bus of the OCM port arbiter: one instance per master.
// The requester uses the master modport; the arbiter uses the slave modport.
interface ocm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ocm_port_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM between the CPU data master (m0)
// and the image-buffer DMA (m1); one access per cycle, read data routed back to its owner.
module ocm_port_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  ocm_port_arbiter_if.slave m0,
  ocm_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic clken_q;
  logic last_grant_q, last_grant_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_owner_q, rd_owner_d;
  logic req0, req1;
  logic grant0, grant1, granted;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // On a tie the master that did not win last time is served.
  assign grant0  = clken_q & req0 & (~req1 | last_grant_q);
  assign grant1  = clken_q & req1 & (~req0 | ~last_grant_q);
  assign granted = grant0 | grant1;

  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;

  assign mem_chipselect = granted;
  assign mem_clken      = clken_q;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    rd_valid_d     = 1'b0;
    if (grant0) begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_write      = m0.write;
      rd_valid_d     = m0.read & ~m0.write;
    end else if (grant1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
      rd_valid_d     = m1.read & ~m1.write;
    end
  end

  assign last_grant_d = granted ? grant1 : last_grant_q;
  assign rd_owner_d   = granted ? grant1 : rd_owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      clken_q      <= 1'b1;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // RAM q is unregistered, so the returning word is valid in the cycle after acceptance.
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_valid_q & ~rd_owner_q;
  assign m1.readdatavalid = rd_valid_q & rd_owner_q;

endmodule

// File: doc/ocm_port_arbiter.md
Name: ocm_port_arbiter

Overview:
- Two-master arbiter sharing the single-port 8192x32 on-chip RAM (13-bit word address, 4-bit byteenable, clken, unregistered q: read data valid one cycle after the address is accepted).
- Requester m0 is the processor data master; requester m1 is the image-buffer DMA.
- Round-robin grant per access; one access accepted per cycle; readdatavalid is routed back to the owning requester.

Parameters:
ADDR_W, 13, memory word-address width
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  requester 0 word address
m0_byteenable  in  BE_W  requester 0 byte lanes
m0_read  in  1  requester 0 read request
m0_write  in  1  requester 0 write request
m0_writedata  in  DATA_W  requester 0 write data
m0_waitrequest  out  1  request not accepted this cycle
m0_readdata  out  DATA_W  read data
m0_readdatavalid  out  1  m0_readdata valid
m1_*  same eight signals as m0_*, for requester 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Reset values (async, reset_n=0): mem_clken=0, last_grant=1, rd_valid_q=0, rd_owner_q=0. All mX_readdatavalid=0, mem_chipselect=0, mem_write=0.
- mem_clken is a register: 0 in reset, 1 from the first clk edge after reset_n rises.
- While mem_clken=0, no grant is issued; any request sees waitrequest=1.
- Request: req_i = mi_read | mi_write. If read and write are both asserted, the access is a write and no read is issued.
- Grant (combinational, valid only when mem_clken=1):
  - Only req_i set: grant i.
  - Both set: grant the index opposite to last_grant.
  - Neither set: no grant.
- last_grant loads the granted index on every granted cycle and holds otherwise. After reset m0 therefore wins the first tie.
- mi_waitrequest = req_i & ~grant_i. It is 0 when idle. Requesters hold their signals stable while waitrequest=1.
- Accepted access = the cycle req_i & grant_i is true.
- mem_chipselect = any grant.
- mem_address, mem_byteenable, mem_writedata and mem_write are muxed from the granted requester. All are 0 when there is no grant.
- Throughput: one access per cycle. A lone requester streams back-to-back with waitrequest=0. Under contention the grants alternate m0, m1, m0, ...
- Read return:
  - rd_valid_q <= granted & read & ~write; rd_owner_q <= granted index.
  - Next cycle: mi_readdatavalid = rd_valid_q & (rd_owner_q==i).
  - mem_readdata is broadcast to both m0_readdata and m1_readdata, qualified only by readdatavalid.
  - Latency is exactly 1 cycle after acceptance, with no reordering.
- Write then read of the same address in consecutive cycles: the read returns the new data, because the RAM is single-port and sequential.
- Write: no response beyond acceptance.
- Reset mid-operation: any in-flight readdatavalid is dropped, with no pulse after reset. The round-robin pointer returns to favour m0.
- Request withdrawn while waiting: this is a protocol violation. The arbiter grants only on the cycle the request is present and keeps no queue.

Test Plan:
- Reset release → mem_clken=0 on the first cycle, with m0_read=1 held and m0_waitrequest=1. mem_clken=1 on the next cycle, the read is accepted, and readdatavalid follows one cycle later.
- m0 writes 0xDEADBEEF to addr 0x0010 with byteenable=0xF, then reads 0x0010 back-to-back → 0 wait cycles; m0_readdatavalid=1 with 0xDEADBEEF exactly 1 cycle after the read is accepted; m1_readdatavalid stays 0.
- m0 and m1 read continuously (addrs 0x100 and 0x200, preloaded 0x11111111 and 0x22222222) → grants m0, m1, m0, m1; each requester sees waitrequest on alternate cycles; readdatavalid pulses alternate with the correct data; no cycle is lost.
- m1 writes 0x000000AB to addr 0x1FFF with byteenable=0x1 over 0xFFFFFFFF → readback gives 0xFFFFFFAB. This checks the top address (wrap boundary) and the byte lanes.
- m0 asserts read and write together on addr 0x0005 → treated as a write, with no readdatavalid pulse.
- m0 read accepted, then reset_n pulsed low for 1 cycle before the data returns → no readdatavalid pulse. After release, m0 wins a simultaneous m0/m1 request.
